// File: rtl/ch0re_ex_mem_reg.sv
// EX->MEM boundary: resolves branches, raises a one-cycle mispredict redirect and
// holds the writeback payload in a 2-entry skid buffer so MEM stalls never reach EX combinationally.
module ch0re_ex_mem_reg #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_alu_res,
  input  logic              i_flag_zero,
  input  logic              i_flag_less,
  input  logic [2:0]        i_br_type,
  input  logic              i_pred_taken,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_br_target,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rd_we,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_res,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_rd_we,
  output logic              o_redirect,
  output logic [XLEN-1:0]   o_redirect_pc
);

  localparam logic [2:0]      BR_NONE = 3'd0;
  localparam logic [2:0]      BR_EQ   = 3'd1;
  localparam logic [2:0]      BR_NE   = 3'd2;
  localparam logic [2:0]      BR_LT   = 3'd3;
  localparam logic [2:0]      BR_GE   = 3'd4;
  localparam logic [2:0]      BR_JMP  = 3'd5;
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  function automatic logic resolve_taken(input logic [2:0] br_type,
                                         input logic zero, input logic less);
    case (br_type)
      BR_EQ:   return zero;
      BR_NE:   return !zero;
      BR_LT:   return less;
      BR_GE:   return !less;
      BR_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic              taken_p0;
  logic              is_cond_p0;
  logic [XLEN-1:0]   pc4_p0;
  logic [XLEN-1:0]   res_p0;
  logic              we_p0;
  logic [XLEN-1:0]   redir_pc_p0;
  logic              acc_p0;
  logic              hs_p0;

  logic              m_vld_p1;
  logic [XLEN-1:0]   m_res_p1;
  logic [REG_AW-1:0] m_rd_p1;
  logic              m_we_p1;
  logic              s_vld_p1;
  logic [XLEN-1:0]   s_res_p1;
  logic [REG_AW-1:0] s_rd_p1;
  logic              s_we_p1;
  logic              redir_p1;
  logic [XLEN-1:0]   redir_pc_p1;

  // Stage p0: combinational resolution of the incoming EX instruction
  always_comb begin
    taken_p0    = resolve_taken(i_br_type, i_flag_zero, i_flag_less);
    is_cond_p0  = (i_br_type == BR_EQ) || (i_br_type == BR_NE) ||
                  (i_br_type == BR_LT) || (i_br_type == BR_GE);
    pc4_p0      = i_pc + FOUR;
    res_p0      = (i_br_type == BR_JMP) ? pc4_p0 : i_alu_res;
    we_p0       = i_rd_we && !is_cond_p0 && (i_rd != '0);
    redir_pc_p0 = taken_p0 ? i_br_target : pc4_p0;
    // A flushed accept is treated as no accept at all
    acc_p0      = i_valid && o_ready && !i_flush;
    hs_p0       = m_vld_p1 && i_ready;
  end

  // Stage p1: skid buffer (M drives outputs, S catches the stall overflow) and redirect
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_vld_p1    <= 1'b0;
      m_res_p1    <= '0;
      m_rd_p1     <= '0;
      m_we_p1     <= 1'b0;
      s_vld_p1    <= 1'b0;
      s_res_p1    <= '0;
      s_rd_p1     <= '0;
      s_we_p1     <= 1'b0;
      redir_p1    <= 1'b0;
      redir_pc_p1 <= '0;
    end else begin
      redir_p1 <= acc_p0 && (taken_p0 != i_pred_taken);
      if (acc_p0) redir_pc_p1 <= redir_pc_p0;

      if (i_flush) begin
        m_vld_p1 <= 1'b0;
        s_vld_p1 <= 1'b0;
      end else if (!m_vld_p1) begin
        m_vld_p1 <= acc_p0;
        if (acc_p0) begin
          m_res_p1 <= res_p0;
          m_rd_p1  <= i_rd;
          m_we_p1  <= we_p0;
        end
      end else if (hs_p0) begin
        // S valid implies o_ready=0, so no accept can coincide with draining S
        if (s_vld_p1) begin
          m_res_p1 <= s_res_p1;
          m_rd_p1  <= s_rd_p1;
          m_we_p1  <= s_we_p1;
          s_vld_p1 <= 1'b0;
        end else if (acc_p0) begin
          m_res_p1 <= res_p0;
          m_rd_p1  <= i_rd;
          m_we_p1  <= we_p0;
        end else begin
          m_vld_p1 <= 1'b0;
        end
      end else if (acc_p0) begin
        s_vld_p1 <= 1'b1;
        s_res_p1 <= res_p0;
        s_rd_p1  <= i_rd;
        s_we_p1  <= we_p0;
      end
    end
  end

  assign o_ready       = !s_vld_p1;
  assign o_valid       = m_vld_p1;
  assign o_res         = m_res_p1;
  assign o_rd          = m_rd_p1;
  assign o_rd_we       = m_we_p1;
  assign o_redirect    = redir_p1;
  assign o_redirect_pc = redir_pc_p1;

endmodule
